muxn_arb: RTL and testbench

Parametrised N-input, WIDTH-bit multiplexer with a registered output stage, per-channel valid/ready handshake and two selection modes: explicit select, and round-robin arbitration. It generalises the datapath select muxes of the multicycle MIPS core to any channel count. It sits wherever several producers share one consumer, such as memory-port or register-write sharing.

---
 rtl/muxn_arb.sv | 98 +++++++++
 tb/tb_muxn_arb.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/muxn_arb.sv
// N-input registered multiplexer with per-channel valid/ready handshake.
// Channel choice is either an explicit select or round-robin arbitration.
module muxn_arb #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  input  logic               out_ready
);

  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  g;
  logic [WIDTH-1:0] g_data;
  logic             found;
  logic             sel_ok;
  logic             g_ok;
  logic             can_accept;
  logic             xfer_in;

  // Channel index visited at scan step k, starting at ptr and wrapping at N.
  function automatic logic [SELW-1:0] rr_idx(input logic [SELW-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= N) s = s - N;
    return SELW'(s);
  endfunction

  assign can_accept = !out_valid || out_ready;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && in_valid[rr_idx(rr_ptr, k)]) begin
        found = 1'b1;
        grant = rr_idx(rr_ptr, k);
      end
    end
  end

  // A select value that names no channel accepts nothing.
  always_comb begin
    sel_ok = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) sel_ok = 1'b1;
    end
  end

  assign g    = mode ? grant : sel;
  assign g_ok = mode ? found : sel_ok;

  always_comb begin
    in_ready = '0;
    g_data   = '0;
    for (int i = 0; i < N; i++) begin
      if (g == SELW'(i)) begin
        in_ready[i] = g_ok && can_accept && !reset;
        g_data      = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer_in = |(in_ready & in_valid);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else begin
      if (xfer_in) begin
        out_valid <= 1'b1;
        out_data  <= g_data;
        out_chan  <= g;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (xfer_in && mode) begin
        rr_ptr <= (g == SELW'(N - 1)) ? '0 : g + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muxn_arb.sv
// Directed bench for muxn_arb: a 4-channel instance for the main behaviour
// and a 3-channel instance for the out-of-range select case.
module tb_muxn_arb;

  localparam int W = 32;

  logic           clk;
  logic           reset;
  logic           mode;
  logic [1:0]     sel;
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_chan;
  logic           out_ready;

  logic           m_reset;
  logic           m_mode;
  logic [1:0]     m_sel;
  logic [2:0]     m_in_valid;
  logic [3*W-1:0] m_in_data;
  logic [2:0]     m_in_ready;
  logic           m_out_valid;
  logic [W-1:0]   m_out_data;
  logic [1:0]     m_out_chan;
  logic           m_out_ready;

  int checks   = 0;
  int failures = 0;

  muxn_arb #(.WIDTH(W), .N(4), .SELW(2)) u_dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
    .out_ready(out_ready)
  );

  muxn_arb #(.WIDTH(W), .N(3), .SELW(2)) u_dut3 (
    .clk(clk), .reset(m_reset), .mode(m_mode), .sel(m_sel),
    .in_valid(m_in_valid), .in_data(m_in_data), .in_ready(m_in_ready),
    .out_valid(m_out_valid), .out_data(m_out_data), .out_chan(m_out_chan),
    .out_ready(m_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are stable afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] ch, input logic [W-1:0] d);
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    check({tag, ".chan"},  64'(out_chan),  64'(ch));
    check({tag, ".data"},  64'(out_data),  64'(d));
  endtask

  initial begin
    reset = 1'b1; mode = 1'b1; sel = '0; in_valid = 4'b1111; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) in_data[i*W +: W] = W'(i);
    m_reset = 1'b1; m_mode = 1'b0; m_sel = 2'd3; m_in_valid = 3'b111; m_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) m_in_data[i*W +: W] = W'(32'h100 + i);

    // Reset held two cycles with every channel valid.
    for (int c = 0; c < 2; c++) begin
      tick();
      check_out("reset", 1'b0, 2'd0, '0);
      check("reset.in_ready", 64'(in_ready), 64'(4'b0000));
    end
    reset = 1'b0; m_reset = 1'b0; out_ready = 1'b1;

    // Round-robin fairness: all valid, consumer always ready.
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("rr%0d.in_ready", k), 64'(in_ready), 64'(4'b0001 << (k % 4)));
      tick();
      check_out($sformatf("rr%0d", k), 1'b1, 2'(k % 4), W'(k % 4));
    end

    // Walk rr_ptr to 3 with a single grant on channel 2.
    in_valid = 4'b0100; #1;
    check("to3.in_ready", 64'(in_ready), 64'(4'b0100));
    tick();
    check_out("to3", 1'b1, 2'd2, W'(2));

    // Skip and wrap: from rr_ptr = 3, channels 0 and 2 requesting.
    in_valid = 4'b0101; #1;
    check("wrap.in_ready", 64'(in_ready), 64'(4'b0001));
    tick();
    check_out("wrap", 1'b1, 2'd0, W'(0));
    #1;
    check("skip.in_ready", 64'(in_ready), 64'(4'b0100));
    tick();
    check_out("skip", 1'b1, 2'd2, W'(2));
    in_valid = 4'b1001; #1;
    check("ptr3.in_ready", 64'(in_ready), 64'(4'b1000));

    // Drain the output register.
    in_valid = 4'b0000; tick();
    check("drain.valid", 64'(out_valid), 64'(1'b0));

    // Explicit select with a stalled consumer.
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b0;
    in_data[2*W +: W] = 32'hDEAD_BEEF; #1;
    check("sel.in_ready", 64'(in_ready), 64'(4'b0100));
    tick();
    check_out("sel", 1'b1, 2'd2, 32'hDEAD_BEEF);
    in_data[2*W +: W] = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall%0d.in_ready", c), 64'(in_ready), 64'(4'b0000));
      tick();
      check_out($sformatf("stall%0d", c), 1'b1, 2'd2, 32'hDEAD_BEEF);
    end
    in_valid = 4'b0000; out_ready = 1'b1; tick();
    check_out("release", 1'b0, 2'd2, 32'hDEAD_BEEF);

    // rr_ptr is still 3: a mode-1 grant to channel 0 moves it to 1.
    mode = 1'b1; in_valid = 4'b0001; #1;
    check("pre.in_ready", 64'(in_ready), 64'(4'b0001));
    tick();
    check_out("pre", 1'b1, 2'd0, W'(0));

    // Drain and refill on the same edge while switching to explicit select.
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data[1*W +: W] = 32'h1111_0001; #1;
    check("refill.in_ready", 64'(in_ready), 64'(4'b0010));
    tick();
    check_out("refill", 1'b1, 2'd1, 32'h1111_0001);
    mode = 1'b1; in_valid = 4'b1111; #1;
    check("ptr_kept.in_ready", 64'(in_ready), 64'(4'b0010));

    // Reset while a transfer is offered discards the word and accepts nothing.
    reset = 1'b1; #1;
    check("rst_mid.in_ready", 64'(in_ready), 64'(4'b0000));
    tick();
    check_out("rst_mid", 1'b0, 2'd0, '0);
    reset = 1'b0; #1;
    check("rst_after.in_ready", 64'(in_ready), 64'(4'b0001));

    // Three-channel instance: select 3 names no channel.
    check("oor.in_ready", 64'(m_in_ready), 64'(3'b000));
    tick();
    check("oor.valid", 64'(m_out_valid), 64'(1'b0));
    tick();
    check("oor.valid2", 64'(m_out_valid), 64'(1'b0));
    m_sel = 2'd1; #1;
    check("sel1.in_ready", 64'(m_in_ready), 64'(3'b010));
    tick();
    check("sel1.chan", 64'(m_out_chan), 64'(2'd1));
    check("sel1.data", 64'(m_out_data), 64'(32'h101));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
